mic_vol_level: RTL and testbench

- Producer side of the 4-bit volume-level interface consumed by the volume-bar renderer.
- Accepts a stream of 12-bit microphone samples and tracks the peak over a fixed sample window.
- Quantises the peak excursion above the silence baseline into a level 0..15, with peak-hold/decay meter behaviour.
- Sits between the mic sampling front end and the OLED display path; drives the `num` input of the bar renderer.

---
 rtl/mic_vol_level.sv | 84 ++++++++
 tb/tb_mic_vol_level.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mic_vol_level.sv
// Mic volume meter: tracks the peak sample over a fixed window and quantises the
// excursion above the silence baseline into a 0..15 bar level with optional decay.
module mic_vol_level #(
    parameter int unsigned WINDOW   = 4000,
    parameter logic [11:0] BASELINE = 12'd2048,
    parameter int unsigned SHIFT    = 7,
    parameter bit          DECAY    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [11:0] mic_in,
    output logic [3:0]  num,
    output logic [11:0] peak,
    output logic        level_valid
);

    localparam logic [15:0] LAST = 16'(WINDOW - 1);

    logic [15:0] cnt_q, cnt_d;
    logic [11:0] run_max_q, run_max_d;
    logic [3:0]  num_q, num_d;
    logic [11:0] peak_q, peak_d;
    logic        lv_q, lv_d;

    logic [11:0] wpk, exc, shifted;
    logic [3:0]  raw;
    logic        last_smp;

    // Window peak always includes the sample being accepted this cycle.
    always_comb begin
        wpk      = (mic_in > run_max_q) ? mic_in : run_max_q;
        exc      = (wpk > BASELINE) ? (wpk - BASELINE) : 12'd0;
        shifted  = exc >> SHIFT;
        raw      = (shifted > 12'd15) ? 4'd15 : shifted[3:0];
        last_smp = (cnt_q == LAST);
    end

    always_comb begin
        cnt_d     = cnt_q;
        run_max_d = run_max_q;
        num_d     = num_q;
        peak_d    = peak_q;
        lv_d      = 1'b0;
        if (sample_valid) begin
            if (last_smp) begin
                cnt_d     = 16'd0;
                run_max_d = 12'd0;
                peak_d    = wpk;
                lv_d      = 1'b1;
                // Instant rise; with decay the fall is limited to one step.
                // raw >= num covers num == 0, so num never wraps.
                if (DECAY && (raw < num_q))
                    num_d = num_q - 4'd1;
                else
                    num_d = raw;
            end else begin
                cnt_d     = cnt_q + 16'd1;
                run_max_d = wpk;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= 16'd0;
            run_max_q <= 12'd0;
            num_q     <= 4'd0;
            peak_q    <= 12'd0;
            lv_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            run_max_q <= run_max_d;
            num_q     <= num_d;
            peak_q    <= peak_d;
            lv_q      <= lv_d;
        end
    end

    assign num         = num_q;
    assign peak        = peak_q;
    assign level_valid = lv_q;

endmodule

// File: tb/tb_mic_vol_level.sv
// Bench for mic_vol_level: a DECAY=1 and a DECAY=0 instance share stimulus and
// are checked against a window-level reference model.
module tb_mic_vol_level;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] mic_in = 12'd0;
    logic [3:0]  num1, num0;
    logic [11:0] peak1, peak0;
    logic        lv1, lv0;

    int checks = 0;
    int passes = 0;

    int win[$];
    int m_num1 = 0, m_num0 = 0, m_peak = 0;

    always #5 clk = ~clk;

    mic_vol_level #(.WINDOW(W), .BASELINE(12'd2048), .SHIFT(7), .DECAY(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .mic_in(mic_in),
        .num(num1), .peak(peak1), .level_valid(lv1));

    mic_vol_level #(.WINDOW(W), .BASELINE(12'd2048), .SHIFT(7), .DECAY(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .mic_in(mic_in),
        .num(num0), .peak(peak0), .level_valid(lv0));

    task automatic strobe(input int v);
        int wpk, exc, raw;
        logic fin;
        sample_valid = 1'b1;
        mic_in = 12'(v);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        fin = 1'b0;
        win.push_back(v);
        if (win.size() == W) begin
            wpk = 0;
            foreach (win[i]) if (win[i] > wpk) wpk = win[i];
            exc = (wpk > 2048) ? wpk - 2048 : 0;
            raw = exc / 128;
            if (raw > 15) raw = 15;
            m_num1 = (raw >= m_num1) ? raw : m_num1 - 1;
            m_num0 = raw;
            m_peak = wpk;
            win.delete();
            fin = 1'b1;
        end
        checks++;
        if (lv1 !== fin || lv0 !== fin)
            $display("FAIL strobe_level_valid: got %b/%b want %b", lv1, lv0, fin);
        else passes++;
        checks++;
        if (num1 !== 4'(m_num1) || num0 !== 4'(m_num0))
            $display("FAIL strobe_num: got %0d/%0d want %0d/%0d", num1, num0, m_num1, m_num0);
        else passes++;
        checks++;
        if (peak1 !== 12'(m_peak) || peak0 !== 12'(m_peak))
            $display("FAIL strobe_peak: got %0d/%0d want %0d", peak1, peak0, m_peak);
        else passes++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            checks++;
            if (lv1 !== 1'b0 || lv0 !== 1'b0 || num1 !== 4'(m_num1) || peak1 !== 12'(m_peak))
                $display("FAIL idle: lv %b/%b num %0d peak %0d want lv 0 num %0d peak %0d",
                         lv1, lv0, num1, peak1, m_num1, m_peak);
            else passes++;
        end
    endtask

    task automatic do_reset(input int cycles, input logic busy);
        rst_n = 1'b0;
        sample_valid = busy;
        mic_in = 12'd4095;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            checks++;
            if (num1 !== 4'd0 || peak1 !== 12'd0 || lv1 !== 1'b0 ||
                num0 !== 4'd0 || peak0 !== 12'd0 || lv0 !== 1'b0)
                $display("FAIL reset_state: num %0d/%0d peak %0d/%0d lv %b/%b want all 0",
                         num1, num0, peak1, peak0, lv1, lv0);
            else passes++;
        end
        rst_n = 1'b1;
        sample_valid = 1'b0;
        win.delete();
        m_num1 = 0; m_num0 = 0; m_peak = 0;
    endtask

    task automatic test_reset();
        do_reset(3, 1'b1);
        // A full window right after release must complete on its 4th strobe.
        for (int i = 0; i < W; i++) strobe(2048 + 256 * i);
        checks++;
        if (num1 !== 4'd6 || peak1 !== 12'd2816)
            $display("FAIL reset_first_window: num %0d peak %0d want 6 2816", num1, peak1);
        else passes++;
    endtask

    task automatic test_quant();
        int a[4] = '{2048, 2100, 2175, 2000};
        int b[4] = '{3000, 2048, 2048, 2048};
        do_reset(1, 1'b0);
        foreach (a[i]) strobe(a[i]);
        checks++;
        if (num1 !== 4'd0 || peak1 !== 12'd2175)
            $display("FAIL quant_w1: num %0d peak %0d want 0 2175", num1, peak1);
        else passes++;
        foreach (b[i]) strobe(b[i]);
        checks++;
        if (num1 !== 4'd7 || peak1 !== 12'd3000)
            $display("FAIL quant_w2: num %0d peak %0d want 7 3000", num1, peak1);
        else passes++;
        idle(2);
    endtask

    task automatic test_decay();
        int exp1[6] = '{15, 14, 13, 12, 12, 15};
        int exp0[6] = '{15, 0, 0, 0, 12, 15};
        int mx[6]   = '{4095, 2048, 2048, 2048, 3584, 4095};
        do_reset(1, 1'b0);
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < W; i++) strobe(i == 2 ? mx[w] : 2048);
            checks++;
            if (num1 !== 4'(exp1[w]) || num0 !== 4'(exp0[w]))
                $display("FAIL decay_w%0d: num %0d/%0d want %0d/%0d", w, num1, num0, exp1[w], exp0[w]);
            else passes++;
        end
    endtask

    task automatic test_gapped();
        int gaps[4] = '{0, 3, 1, 5};
        int v[4]    = '{2048, 2560, 2048, 2048};
        do_reset(1, 1'b0);
        foreach (v[i]) begin
            idle(gaps[i]);
            strobe(v[i]);
        end
        checks++;
        if (num1 !== 4'd4 || peak1 !== 12'd2560 || num0 !== 4'd4)
            $display("FAIL gapped: num %0d/%0d peak %0d want 4/4 2560", num1, num0, peak1);
        else passes++;
        idle(3);
    endtask

    task automatic test_reset_mid();
        do_reset(1, 1'b0);
        strobe(4095);
        strobe(4095);
        do_reset(1, 1'b0);
        for (int i = 0; i < W; i++) strobe(2304);
        checks++;
        if (num1 !== 4'd2 || peak1 !== 12'd2304)
            $display("FAIL reset_mid: num %0d peak %0d want 2 2304", num1, peak1);
        else passes++;
    endtask

    task automatic test_back_to_back_random();
        do_reset(1, 1'b0);
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            case ($urandom_range(0, 2))
                0: strobe($urandom_range(0, 4095));
                1: strobe($urandom_range(1900, 2400));
                default: strobe($urandom_range(2048, 4095));
            endcase
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_quant();
        test_decay();
        test_gapped();
        test_reset_mid();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
